// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if: bridges core load/store requests onto a classic Wishbone master cycle.
// Optional bus-cycle timeout with bus_err_o pulse is enabled by defining WB_TIMEOUT_EN.
module wishbone_bus_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;
  state_t      r_state;
  logic [31:0] r_rd_buf;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [3:0]  r_sel;
  logic        r_stb;
  logic        r_cyc;
  logic        w_stall;
  logic        w_done;
  logic        w_start;
  logic        w_timeout;
  logic        w_err_hold;
  assign w_stall = |stall_i;
  assign w_done  = r_state == BUSY && wishbone_ack_i && !flush_i;
  assign w_start = r_state == IDLE && cpu_ce_i && !flush_i && !w_err_hold;
`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;
  assign w_timeout  = r_state == BUSY && !wishbone_ack_i && !flush_i && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_err_hold = r_bus_err;
  assign bus_err_o  = r_bus_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      r_cnt     <= (w_start || w_timeout) ? '0 : (r_state == BUSY && !wishbone_ack_i) ? r_cnt + CW'(1) : r_cnt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout  = 1'b0;
  assign w_err_hold = 1'b0;
  assign bus_err_o  = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_buf <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= cpu_addr_i;
      r_data  <= cpu_data_i;
      r_we    <= cpu_we_i;
      r_sel   <= cpu_sel_i;
      r_stb   <= 1'b1;
      r_cyc   <= 1'b1;
      r_state <= BUSY;
    end else if (r_state == BUSY && (flush_i || wishbone_ack_i || w_timeout)) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_rd_buf <= w_done ? (r_we ? r_rd_buf : wishbone_data_i) : '0;
      r_state  <= (w_done && w_stall) ? WAIT_FOR_STALL : IDLE;
    end else if (r_state == WAIT_FOR_STALL && !w_stall) begin
      r_state <= IDLE;
    end
  end
  assign wishbone_addr_o = r_addr;
  assign wishbone_data_o = r_data;
  assign wishbone_we_o   = r_we;
  assign wishbone_sel_o  = r_sel;
  assign wishbone_stb_o  = r_stb;
  assign wishbone_cyc_o  = r_cyc;
  // rst gates stallreq so a pending cpu_ce_i cannot hold the pipeline during reset
  assign stallreq   = !rst && (w_start || (r_state == BUSY && !wishbone_ack_i));
  assign cpu_data_o = (w_done && !r_we) ? wishbone_data_i : (r_state == WAIT_FOR_STALL) ? r_rd_buf : '0;
endmodule
